dft_interp2: RTL

//   2x upsampler that mirrors the 2:1 averaging decimator feeding the DFT.

---
 rtl/dft_pkg.sv | 13 +
 rtl/dft_interp_mid.sv | 25 ++
 rtl/dft_interp2.sv | 118 +++++++++++
 3 files changed

// File: rtl/dft_pkg.sv
// Shared definitions for the DFT pre/post-processing blocks:
// default sample width and the interpolator state encoding.
package dft_pkg;

  localparam int DATA_W_DEF = 12;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MID   = 2'd1,
    SAMP  = 2'd2
  } interp_state_t;

endpackage

// File: rtl/dft_interp_mid.sv
// Midpoint of two signed samples: floor((prev+x)/2), or round-half-up
// when INTERP_ROUND_EN is defined. One guard bit, so the result never wraps.
module dft_interp_mid
  import dft_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic signed [DATA_W-1:0] prev,
  input  logic signed [DATA_W-1:0] x,
  output logic signed [DATA_W-1:0] mid
);

  logic signed [DATA_W:0] sum;

  always_comb begin
    sum = {prev[DATA_W-1], prev} + {x[DATA_W-1], x};
`ifdef INTERP_ROUND_EN
    // max+max+1 still fits in DATA_W+1 bits, and halving lands back on max
    mid = DATA_W'((sum + (DATA_W+1)'(1)) >>> 1);
`else
    mid = DATA_W'(sum >>> 1);
`endif
  end

endmodule

// File: rtl/dft_interp2.sv
// 2x upsampler: each input x[n] yields mid(x[n-1],x[n]) then x[n].
// Midpoint rounding selected by INTERP_ROUND_EN (see dft_interp_mid).
//
// state | meaning
// EMPTY | no output pending; ready for a new sample
// MID   | midpoint presented on data_out, waiting for transfer
// SAMP  | sample presented on data_out; may accept the next input on transfer
module dft_interp2
  import dft_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     valid_in,
  input  logic                     frame_in,
  output logic                     ready_in,
  output logic signed [DATA_W-1:0] data_out,
  output logic                     valid_out,
  input  logic                     ready_out
);

  interp_state_t state_q, state_d;

  logic signed [DATA_W-1:0] prev_q;
  logic signed [DATA_W-1:0] cur_q;
  logic signed [DATA_W-1:0] mid_prev;
  logic signed [DATA_W-1:0] mid_val;

  logic accept;
  logic xfer;
  logic ld_mid;
  logic ld_samp;
  logic clr_valid;
  logic upd_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = MID;
      MID:     if (xfer) state_d = SAMP;
      SAMP:    if (xfer) state_d = accept ? MID : EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    ready_in  = 1'b0;
    ld_samp   = 1'b0;
    clr_valid = 1'b0;
    upd_prev  = 1'b0;
    case (state_q)
      EMPTY: ready_in = !rst;
      MID:   ld_samp = xfer;
      SAMP: begin
        ready_in  = !rst && ready_out;
        upd_prev  = xfer;
        clr_valid = xfer && !(valid_in && ready_in);
      end
      default: ready_in = 1'b0;
    endcase
    accept = valid_in && ready_in;
    xfer   = valid_out && ready_out;
    ld_mid = accept;
  end

  // In SAMP the history register is only updated at this same edge,
  // so a back-to-back midpoint must take its history from cur_q.
  always_comb begin
    if (frame_in) begin
      mid_prev = data_in;
    end else if (state_q == SAMP) begin
      mid_prev = cur_q;
    end else begin
      mid_prev = prev_q;
    end
  end

  dft_interp_mid #(
    .DATA_W(DATA_W)
  ) u_mid (
    .prev(mid_prev),
    .x   (data_in),
    .mid (mid_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q    <= '0;
      cur_q     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      if (ld_mid) begin
        data_out  <= mid_val;
        cur_q     <= data_in;
        valid_out <= 1'b1;
      end else if (ld_samp) begin
        data_out <= cur_q;
      end else if (clr_valid) begin
        valid_out <= 1'b0;
      end
      if (upd_prev) begin
        prev_q <= cur_q;
      end
    end
  end

endmodule
